// File: rtl/line_buffer_pixel_feeder.sv
// Frame-scan pixel source: reads a raster-ordered frame from a 1-cycle-latency memory and
// streams it out over valid/ready. It has a registered output stage plus one skid slot, and tags
// sof/eol/eof on the stream.
module line_buffer_pixel_feeder #(
  parameter int unsigned IMG_W  = 512,
  parameter int unsigned IMG_H  = 512,
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned ROW_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic [7:0]        pix_data_o,
  output logic              sof_o,
  output logic              eol_o,
  output logic              eof_o,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COL_W-1:0]  LastCol  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  LastRow  = ROW_W'(IMG_H - 1);

  // StDone is the one-cycle done_o pulse after the eof transfer; still counted as busy.
  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_pend_q;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                skid_valid_q, skid_valid_d;
  logic [7:0]          skid_data_q, skid_data_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;

  logic       xfer;
  logic       at_eof;
  logic [1:0] occ;
  logic       rd_issue;

  assign xfer   = out_valid_q & pix_ready_i;
  assign at_eof = out_valid_q && (col_q == LastCol) && (row_q == LastRow);
  // Filled slots plus the read in flight; never more than the two slots can absorb.
  assign occ    = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q);
  assign rd_issue = (state_q == StRun) && ((occ < 2'd2) || ((occ == 2'd2) && xfer));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_addr_q    <= '0;
      rd_pend_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      col_q        <= '0;
      row_q        <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      rd_pend_q    <= rd_issue;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      col_q        <= col_d;
      row_q        <= row_d;
    end
  end

  // Next-state logic for the scan FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (rd_issue && (rd_addr_q == LastAddr)) state_d = StDrain;
      StDrain: if (xfer && at_eof) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM-derived outputs and stream outputs.
  always_comb begin
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StDone);
    mem_re_o    = rd_issue;
    mem_addr_o  = rd_addr_q;
    pix_valid_o = out_valid_q;
    pix_data_o  = out_data_q;
    col_o       = col_q;
    row_o       = row_q;
    sof_o       = out_valid_q && (col_q == '0) && (row_q == '0);
    eol_o       = out_valid_q && (col_q == LastCol);
    eof_o       = at_eof;
  end

  // Read address: clears in idle, advances per issued read, parks on the last address.
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (state_q == StIdle) begin
      rd_addr_d = '0;
    end else if (rd_issue && (rd_addr_q != LastAddr)) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end
  end

  // Output/skid slots: the skid holds the older pixel, so it refills the output first.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || xfer) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = rd_pend_q;
        if (rd_pend_q) skid_data_d = mem_data_i;
      end else if (rd_pend_q) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (rd_pend_q) begin
      // The issue gate guarantees the skid is empty here.
      skid_valid_d = 1'b1;
      skid_data_d  = mem_data_i;
    end
  end

  // Position of the presented pixel; wraps to (0,0) after the eof transfer.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == StIdle) begin
      col_d = '0;
      row_d = '0;
    end else if (xfer) begin
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = (row_q == LastRow) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_pixel_feeder.sv
// Bench for line_buffer_pixel_feeder on a 4x3 frame: directed ready patterns plus random frames,
// each checked against a raster-order reference of the memory contents.
module tb_line_buffer_pixel_feeder;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       busy_o, done_o, mem_re_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_data_i;
  logic       pix_valid_o, pix_ready_i;
  logic [7:0] pix_data_o;
  logic       sof_o, eol_o, eof_o;
  logic [1:0] col_o, row_o;

  logic [7:0] mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  line_buffer_pixel_feeder #(
    .IMG_W (W),
    .IMG_H (H),
    .ADDR_W(4),
    .COL_W (2),
    .ROW_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .mem_re_o   (mem_re_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .pix_valid_o(pix_valid_o),
    .pix_ready_i(pix_ready_i),
    .pix_data_o (pix_data_o),
    .sof_o      (sof_o),
    .eol_o      (eol_o),
    .eof_o      (eof_o),
    .col_o      (col_o),
    .row_o      (row_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read frame memory.
  always @(posedge clk) begin
    if (mem_re_o) mem_data_i <= mem[mem_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({busy_o, done_o, mem_re_o, mem_addr_o, pix_valid_o, pix_data_o,
                sof_o, eol_o, eof_o, col_o, row_o});
  endfunction

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < 16; i++) mem[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  // mode: 0 ready high, 1 ready 1,0,0,1 repeating, 2 ready low 10 cycles from first valid,
  // 3 random ready. Entered and left at posedge+1.
  task automatic run_frame(input int mode, input bit extra_start, input int abort_after);
    int cyc = 1;
    int n_iss = 0, n_xfer = 0, n_done = 0, stall_cnt = 0;
    int t_first_re = -1, t_first_v = -1, t_done = -1, t_eof = -1;
    bit stop = 0, aborted = 0, prev_stall = 0;
    logic [7:0] p_data;
    logic [1:0] p_col, p_row;
    logic [2:0] p_tags;
    int k;

    start_i = 1'b1;
    pix_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    while (cyc < 200 && !stop) begin
      case (mode)
        0: pix_ready_i = 1'b1;
        1: pix_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
        2: begin
          pix_ready_i = (stall_cnt >= 10);
          if (pix_valid_o) stall_cnt++;
        end
        default: pix_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      start_i = extra_start && (cyc == 6);
      #3;
      if (done_o && extra_start) start_i = 1'b1;

      check("outstanding_le3", 32'((n_iss - n_xfer) <= 3), 32'd1);
      if (mem_re_o) begin
        check("rd_addr", 32'(mem_addr_o), 32'(n_iss));
        if (t_first_re < 0) t_first_re = cyc;
        n_iss++;
      end
      if (prev_stall) begin
        check("stall_data", 32'(pix_data_o), 32'(p_data));
        check("stall_pos", 32'({col_o, row_o}), 32'({p_col, p_row}));
        check("stall_tags", 32'({sof_o, eol_o, eof_o}), 32'(p_tags));
      end
      if (!pix_valid_o) check("tags_idle", 32'({sof_o, eol_o, eof_o}), 32'd0);
      if (pix_valid_o && t_first_v < 0) t_first_v = cyc;
      if (mode == 2 && cyc == 12) begin
        check("stall_reads", 32'(n_iss), 32'd2);
        check("stall_hold0", 32'(pix_data_o), 32'd0);
      end
      if (pix_valid_o && pix_ready_i) begin
        k = n_xfer;
        check("pix_data", 32'(pix_data_o), 32'(mem[k]));
        check("col", 32'(col_o), 32'(k % W));
        check("row", 32'(row_o), 32'(k / W));
        check("sof", 32'(sof_o), 32'(k == 0));
        check("eol", 32'(eol_o), 32'(k % W == W - 1));
        check("eof", 32'(eof_o), 32'(k == N - 1));
        if (k == N - 1) t_eof = cyc;
        n_xfer++;
      end
      if (n_done == 0) check("busy_run", 32'(busy_o), 32'd1);
      if (done_o) begin
        n_done++;
        t_done = cyc;
        stop = 1;
      end
      prev_stall = pix_valid_o && !pix_ready_i;
      p_data = pix_data_o;
      p_col  = col_o;
      p_row  = row_o;
      p_tags = {sof_o, eol_o, eof_o};
      if (abort_after > 0 && n_xfer == abort_after) begin
        aborted = 1;
        stop = 1;
        rst = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;

    if (aborted) begin
      rst = 1'b0;
      #3;
      check("abort_zero", all_outs(), 32'd0);
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #4;
        check("abort_quiet", 32'({busy_o, done_o, mem_re_o}), 32'd0);
      end
      @(posedge clk); #1;
    end else if (t_done < 0) begin
      check("timeout_done", 32'd0, 32'd1);
    end else begin
      #3;
      check("busy_after", 32'({busy_o, done_o}), 32'd0);
      check("n_xfer", 32'(n_xfer), 32'(N));
      check("n_iss", 32'(n_iss), 32'(N));
      check("n_done", 32'(n_done), 32'd1);
      check("done_after_eof", 32'(t_done), 32'(t_eof + 1));
      if (mode == 0) begin
        check("lat_first_re", 32'(t_first_re), 32'd1);
        check("lat_first_valid", 32'(t_first_v), 32'd3);
        check("lat_done", 32'(t_done), 32'd15);
      end
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #4;
        check("idle_no_restart", 32'({busy_o, mem_re_o}), 32'd0);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b1;
    pix_ready_i = 1'b1;
    fill_mem(0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #4;
      check("reset_outs", all_outs(), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #4;
      check("idle_outs", all_outs(), 32'd0);
    end
    @(posedge clk); #1;

    run_frame(0, 0, 0);
    run_frame(1, 0, 0);
    run_frame(2, 0, 0);
    run_frame(0, 1, 0);
    run_frame(0, 0, 5);
    run_frame(0, 0, 0);
    for (int f = 0; f < 4; f++) begin
      fill_mem(1);
      run_frame(3, (f % 2) == 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_pixel_feeder.md
Name: line_buffer_pixel_feeder

Overview:
- Frame-scan source for the Sobel line-buffer chain.
- On start, it reads an IMG_W x IMG_H 8-bit greyscale frame in raster order from a synchronous-read frame memory (1-cycle read latency).
- It emits the pixels as a valid/ready stream. pix_valid_o && pix_ready_i forms the line buffer's write enable.
- It supports downstream backpressure, tags frame and line boundaries, and pulses done after the last pixel is accepted.

Parameters:
- IMG_W, 512, pixels per line (>=2).
- IMG_H, 512, lines per frame (>=2).
- ADDR_W, 18, frame memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- COL_W, 10, width of col_o; must satisfy 2^COL_W > IMG_W-1.
- ROW_W, 10, width of row_o; must satisfy 2^ROW_W > IMG_H-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin one frame scan; sampled only in IDLE.
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle pulse: frame fully accepted downstream.
- mem_re_o  out  1  frame memory read enable.
- mem_addr_o  out  ADDR_W  read address, raster index row*IMG_W+col.
- mem_data_i  in  8  read data, valid exactly 1 cycle after mem_re_o.
- pix_valid_o  out  1  output pixel valid.
- pix_ready_i  in  1  downstream ready; transfer occurs when valid&&ready.
- pix_data_o  out  8  output pixel.
- sof_o  out  1  qualifies the pixel at (0,0).
- eol_o  out  1  qualifies the pixel at col IMG_W-1.
- eof_o  out  1  qualifies the pixel at (IMG_W-1, IMG_H-1).
- col_o  out  COL_W  column of the current output pixel.
- row_o  out  ROW_W  row of the current output pixel.

Behaviour:
- Reset values: all outputs 0. State is IDLE, read and output counters are 0, skid buffer is empty.
- rst applied mid-frame aborts immediately. No done_o pulse is produced. The next frame needs a new start_i.
- FSM state IDLE:
  - start_i=1 moves to RUN next cycle.
  - Read address and output counters clear to 0.
- FSM state RUN:
  - Issues reads at addresses 0..IMG_W*IMG_H-1, in order.
  - Moves to DRAIN in the cycle after the last address is issued.
- FSM state DRAIN:
  - No reads are issued.
  - Waits for the last pixel (eof) to transfer.
  - Moves to IDLE with a done_o pulse in the cycle after the eof transfer.
- Busy and start handling:
  - busy_o=1 in RUN and DRAIN.
  - start_i is ignored while busy.
  - start_i in the same cycle as done_o is ignored. A new start is accepted only in IDLE.
- Datapath:
  - Registered output stage plus one skid register, giving 2 pixel slots.
  - occ = filled slots + reads in flight (0..3).
  - A read is issued when RUN && addresses remain && (occ<2 || (occ==2 && transfer this cycle)).
  - Returned data goes to the output register if it is free or transferring, else to the skid register.
  - Nothing is ever dropped or duplicated.
- Latency:
  - start_i high at cycle T gives mem_re_o=1, addr 0 at T+1.
  - pix_valid_o=1 with pixel 0 and sof_o at T+3.
- Throughput:
  - 1 pixel/cycle while pix_ready_i=1.
  - Frame takes IMG_W*IMG_H cycles plus 3 cycles of fill.
  - With ready held high, done_o occurs at T+3+IMG_W*IMG_H.
- Stability: while pix_valid_o && !pix_ready_i, pix_data_o, col_o, row_o, sof_o, eol_o and eof_o hold stable.
- Counters and tags:
  - col and row advance on each transfer.
  - col wraps IMG_W-1 to 0 and increments row.
  - sof, eol and eof are derived from col and row of the pixel being presented.
  - They are 0 whenever pix_valid_o=0.
- Address arithmetic:
  - mem_addr_o increments by 1 per issued read and stops at IMG_W*IMG_H-1.
  - mem_addr_o holds its last value when mem_re_o=0.
- pix_ready_i is don't-care while pix_valid_o=0. It may be low from the very first pixel.

Test Plan (IMG_W=4, IMG_H=3, memory preloaded with value = address):
- Reset, no start: all outputs stay 0 for 20 cycles; start during reset is ignored.
- start_i at T, ready held high:
  - mem_re_o at T+1..T+12 with addresses 0..11.
  - pix_data_o = 0..11 at T+3..T+14.
  - sof at T+3; eol at data 3, 7, 11; eof at data 11.
  - done_o at T+15 only; busy_o high from T+1 to T+15, low at T+16.
- Ready toggling 1,0,0,1 repeating: exactly 12 transfers carrying 0..11 in order, no gaps or repeats. Outputs are stable during every stall. Reads never exceed 3 outstanding entries.
- Ready low from the first valid for 10 cycles, then high:
  - pix_data_o holds 0 during the stall.
  - Reads stop after address 1.
  - Stream resumes 0..11 intact and done_o follows the eof transfer.
- Second start_i asserted mid-frame: ignored; exactly one done_o is produced. start_i in the done_o cycle is also ignored.
- rst asserted after 5 transfers: next cycle all outputs are 0 and no done_o occurs. A new start_i restarts from address 0 with sof set.
